quadrature_encoder_frontend: RTL and testbench

//  Front end for the BLDC encoder inputs. Each raw encoder_a/encoder_b pin gets a multi-flop synchronizer.
//  A per-channel glitch filter follows, then a quadrature decoder. The block produces a signed tick count,
//  a one-cycle state_change strobe and a direction flag for the tick timer and torque-vector stages.

---
 rtl/quadrature_encoder_frontend.sv | 165 ++++++++++++++++
 tb/tb_quadrature_encoder_frontend.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_encoder_frontend.sv
// Synchronizes and deglitches encoder A/B, decodes quadrature steps into a signed count, direction, strobe and error stats.
// Latency: pin edge to count/strobe is SYNC_STAGES+FILTER_CYCLES+1 clocks; free-running, no backpressure.
module quadrature_encoder_frontend #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   encoder_a,
    input  logic                   encoder_b,
    input  logic                   clear_count,
    input  logic                   clear_errors,
    output logic [COUNT_WIDTH-1:0] encoder_count,
    output logic                   state_change,
    output logic                   count_dir,
    output logic                   quad_error,
    output logic [7:0]             error_count,
    output logic                   primed
);

    localparam int PRIME_CLKS = SYNC_STAGES + FILTER_CYCLES;
    localparam int FCW        = $clog2(FILTER_CYCLES + 1);
    localparam int PCW        = $clog2(PRIME_CLKS + 1);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Channel index 1 is A, 0 is B, so {x[1],x[0]} reads as {A,B}.
    logic [1:0]             raw_ab;
    logic [SYNC_STAGES-1:0] sync_ch [2];
    logic [1:0]             s_ab;
    logic [1:0]             f_ab;
    logic [1:0]             p_ab;
    logic [FCW-1:0]         flt_cnt [2];
    logic [PCW-1:0]         prime_cnt;
    logic                   prime_done;
    logic [1:0]             pos_cur;
    logic [1:0]             pos_prv;
    logic [1:0]             step;
    logic                   step_fwd;
    logic                   step_rev;
    logic                   step_ill;

    assign raw_ab = {encoder_a, encoder_b};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                sync_ch[i] <= '0;
            end else begin
                sync_ch[i] <= {sync_ch[i][SYNC_STAGES-2:0], raw_ab[i]};
            end
        end
    end

    always_comb begin
        s_ab = '0;
        for (int i = 0; i < 2; i++) begin
            s_ab[i] = sync_ch[i][SYNC_STAGES-1];
        end
    end

    // While priming, track the pins directly so the first RUN compare starts from the settled level.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                f_ab[i]    <= 1'b0;
                flt_cnt[i] <= '0;
            end else if (state_q == PRIME) begin
                f_ab[i]    <= s_ab[i];
                flt_cnt[i] <= '0;
            end else if (s_ab[i] == f_ab[i]) begin
                flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FCW'(FILTER_CYCLES - 1)) begin
                f_ab[i]    <= s_ab[i];
                flt_cnt[i] <= '0;
            end else begin
                flt_cnt[i] <= flt_cnt[i] + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PRIME;
            prime_cnt <= '0;
            p_ab      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == PRIME) begin
                prime_cnt <= prime_cnt + PCW'(1);
            end
            if (prime_done || state_q == RUN) begin
                p_ab <= f_ab;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        prime_done = 1'b0;
        case (state_q)
            PRIME: begin
                if (prime_cnt == PCW'(PRIME_CLKS - 1)) begin
                    state_d    = RUN;
                    prime_done = 1'b1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = PRIME;
        endcase
    end

    // Gray-to-binary position: the forward sequence 00,10,11,01 maps to 0,1,2,3.
    always_comb begin
        pos_cur  = {f_ab[0], f_ab[1] ^ f_ab[0]};
        pos_prv  = {p_ab[0], p_ab[1] ^ p_ab[0]};
        step     = pos_cur - pos_prv;
        step_fwd = (state_q == RUN) && (step == 2'd1);
        step_rev = (state_q == RUN) && (step == 2'd3);
        step_ill = (state_q == RUN) && (step == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            encoder_count <= '0;
            state_change  <= 1'b0;
            count_dir     <= 1'b0;
            quad_error    <= 1'b0;
            error_count   <= '0;
        end else begin
            state_change <= step_fwd | step_rev;
            if (step_fwd) begin
                encoder_count <= encoder_count + COUNT_WIDTH'(1);
                count_dir     <= 1'b1;
            end else if (step_rev) begin
                encoder_count <= encoder_count - COUNT_WIDTH'(1);
                count_dir     <= 1'b0;
            end
            if (clear_count) begin
                encoder_count <= '0;
            end
            // A new error in the clearing cycle survives the clear.
            if (step_ill) begin
                quad_error <= 1'b1;
                if (clear_errors) begin
                    error_count <= 8'd1;
                end else if (error_count != 8'hFF) begin
                    error_count <= error_count + 8'd1;
                end
            end else if (clear_errors) begin
                quad_error  <= 1'b0;
                error_count <= '0;
            end
        end
    end

    assign primed = (state_q == RUN);

endmodule

// File: tb/tb_quadrature_encoder_frontend.sv
// Directed bench for quadrature_encoder_frontend: a pin-history model checked every cycle plus literal checkpoints.
module tb_quadrature_encoder_frontend;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          encoder_a;
    logic          encoder_b;
    logic          clear_count;
    logic          clear_errors;
    logic [CW-1:0] encoder_count;
    logic          state_change;
    logic          count_dir;
    logic          quad_error;
    logic [7:0]    error_count;
    logic          primed;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    quadrature_encoder_frontend #(
        .SYNC_STAGES  (SYNC),
        .FILTER_CYCLES(FILT),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .encoder_a    (encoder_a),
        .encoder_b    (encoder_b),
        .clear_count  (clear_count),
        .clear_errors (clear_errors),
        .encoder_count(encoder_count),
        .state_change (state_change),
        .count_dir    (count_dir),
        .quad_error   (quad_error),
        .error_count  (error_count),
        .primed       (primed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Forward order of {A,B} codes; a step's direction is its distance along this ring.
    int       fwd_seq [4] = '{0, 2, 3, 1};
    bit       q_a [$];
    bit       q_b [$];
    bit       w_a [$];
    bit       w_b [$];
    bit       m_fa, m_fb, m_pa, m_pb, m_run;
    int       m_prime;
    bit [CW-1:0] m_count;
    bit       m_sc, m_dir, m_qe;
    int       m_ec;

    function automatic int pos_of(input bit a, input bit b);
        int v;
        v = 2 * int'(a) + int'(b);
        for (int i = 0; i < 4; i++) begin
            if (fwd_seq[i] == v) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        bit sa, sb, ofa, ofb, fwd, rev, ill, held_a, held_b;
        int d;
        if (reset) begin
            q_a.delete();
            q_b.delete();
            for (int i = 0; i < SYNC; i++) begin
                q_a.push_back(1'b0);
                q_b.push_back(1'b0);
            end
            w_a.delete();
            w_b.delete();
            m_fa = 0; m_fb = 0; m_pa = 0; m_pb = 0; m_run = 0; m_prime = 0;
            m_count = '0; m_sc = 0; m_dir = 0; m_qe = 0; m_ec = 0;
        end else begin
            // Post-sync level seen by this edge is the pin sampled SYNC edges ago.
            sa = q_a.pop_front();
            sb = q_b.pop_front();
            q_a.push_back(encoder_a);
            q_b.push_back(encoder_b);
            w_a.push_back(sa);
            w_b.push_back(sb);
            if (w_a.size() > FILT) void'(w_a.pop_front());
            if (w_b.size() > FILT) void'(w_b.pop_front());
            ofa = m_fa;
            ofb = m_fb;
            fwd = 0; rev = 0; ill = 0;
            m_sc = 0;
            if (!m_run) begin
                m_fa = sa;
                m_fb = sb;
                m_prime++;
                if (m_prime == SYNC + FILT) begin
                    m_run = 1;
                    m_pa  = ofa;
                    m_pb  = ofb;
                end
            end else begin
                d   = (pos_of(ofa, ofb) - pos_of(m_pa, m_pb) + 4) % 4;
                fwd = (d == 1);
                rev = (d == 3);
                ill = (d == 2);
                m_pa = ofa;
                m_pb = ofb;
                // A new level is accepted once it has persisted for the last FILT post-sync samples.
                held_a = (w_a.size() == FILT);
                foreach (w_a[i]) if (w_a[i] == ofa) held_a = 0;
                held_b = (w_b.size() == FILT);
                foreach (w_b[i]) if (w_b[i] == ofb) held_b = 0;
                if (held_a) m_fa = ~ofa;
                if (held_b) m_fb = ~ofb;
            end
            if (fwd) begin m_count = m_count + 1; m_dir = 1; m_sc = 1; end
            if (rev) begin m_count = m_count - 1; m_dir = 0; m_sc = 1; end
            if (clear_count) m_count = '0;
            if (clear_errors) begin m_qe = 0; m_ec = 0; end
            if (ill) begin
                m_qe = 1;
                if (m_ec < 255) m_ec++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_count", encoder_count, m_count);
            chk("cyc_strobe", state_change, 32'(m_sc));
            chk("cyc_dir", count_dir, 32'(m_dir));
            chk("cyc_qerr", quad_error, 32'(m_qe));
            chk("cyc_errcnt", error_count, 32'(m_ec));
            chk("cyc_primed", primed, 32'(m_run));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_pos(input int p);
        encoder_a = (p == 1 || p == 2);
        encoder_b = (p == 2 || p == 3);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pos;
        int n_sc;
        int bad_lat;
        reset        = 1'b1;
        encoder_a    = 1'b1;
        encoder_b    = 1'b1;
        clear_count  = 1'b0;
        clear_errors = 1'b0;
        wait_clks(3);
        chk_en = 1;

        // 1: reset state, priming with A=B=1
        chk("rst_count", encoder_count, 32'h0);
        chk("rst_primed", primed, 32'h0);
        chk("rst_errcnt", error_count, 32'h0);
        reset = 1'b0;
        wait_clks(5);
        chk("primed_after5", primed, 32'h0);
        wait_clks(1);
        chk("primed_after6", primed, 32'h1);
        wait_clks(10);
        chk("prime_count", encoder_count, 32'h0);
        chk("prime_qerr", quad_error, 32'h0);

        // 2: eight forward steps, strobe exactly on the 7th edge
        pos     = 2;
        n_sc    = 0;
        bad_lat = 0;
        for (int k = 0; k < 8; k++) begin
            pos = (pos + 1) % 4;
            set_pos(pos);
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (state_change) begin
                    n_sc++;
                    if (c != 7) bad_lat++;
                end
            end
        end
        chk("fwd_strobes", n_sc, 32'd8);
        chk("fwd_latency", bad_lat, 32'd0);
        chk("fwd_count", encoder_count, 32'd8);
        chk("fwd_dir", count_dir, 32'h1);

        // 3: reverse from zero wraps below zero
        clear_count = 1'b1;
        wait_clks(1);
        clear_count = 1'b0;
        chk("clr_count", encoder_count, 32'h0);
        for (int k = 0; k < 3; k++) begin
            pos = (pos + 3) % 4;
            set_pos(pos);
            wait_clks(20);
        end
        chk("rev_count", encoder_count, 32'hFFFF_FFFD);
        chk("rev_dir", count_dir, 32'h0);

        // 4: 3-clock glitch on A is swallowed
        n_sc = 0;
        encoder_a = ~encoder_a;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (state_change) n_sc++;
        end
        encoder_a = ~encoder_a;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (state_change) n_sc++;
        end
        chk("glitch_strobes", n_sc, 32'd0);
        chk("glitch_count", encoder_count, 32'hFFFF_FFFD);

        // 5: illegal 00->11, clear, then saturate
        pos = (pos + 1) % 4;
        set_pos(pos);
        wait_clks(20);
        chk("to00_count", encoder_count, 32'hFFFF_FFFE);
        set_pos(2);
        wait_clks(20);
        chk("ill_qerr", quad_error, 32'h1);
        chk("ill_errcnt", error_count, 32'd1);
        chk("ill_count", encoder_count, 32'hFFFF_FFFE);
        clear_errors = 1'b1;
        wait_clks(1);
        clear_errors = 1'b0;
        chk("clrerr_qerr", quad_error, 32'h0);
        chk("clrerr_errcnt", error_count, 32'h0);
        for (int k = 0; k < 300; k++) begin
            encoder_a = ~encoder_a;
            encoder_b = ~encoder_b;
            wait_clks(6);
        end
        wait_clks(4);
        chk("sat_errcnt", error_count, 32'd255);
        chk("sat_qerr", quad_error, 32'h1);
        chk("sat_count", encoder_count, 32'hFFFF_FFFE);
        // clear_errors on the same edge as a new illegal step
        set_pos(0);
        wait_clks(6);
        clear_errors = 1'b1;
        wait_clks(1);
        clear_errors = 1'b0;
        chk("clrerr_ill_errcnt", error_count, 32'd1);
        chk("clrerr_ill_qerr", quad_error, 32'h1);
        pos = 0;

        // 6: clear_count colliding with a step, then reset mid-run
        clear_count = 1'b1;
        wait_clks(1);
        clear_count = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pos = (pos + 1) % 4;
            set_pos(pos);
            wait_clks(20);
        end
        chk("pre_clr_count", encoder_count, 32'd5);
        pos = (pos + 1) % 4;
        set_pos(pos);
        wait_clks(6);
        clear_count = 1'b1;
        wait_clks(1);
        clear_count = 1'b0;
        chk("clrwin_count", encoder_count, 32'h0);
        chk("clrwin_strobe", state_change, 32'h1);
        chk("clrwin_dir", count_dir, 32'h1);
        wait_clks(5);
        reset = 1'b1;
        wait_clks(1);
        chk("midrst_primed", primed, 32'h0);
        chk("midrst_qerr", quad_error, 32'h0);
        chk("midrst_errcnt", error_count, 32'h0);
        chk("midrst_dir", count_dir, 32'h0);
        reset = 1'b0;
        wait_clks(12);
        chk("reprime_primed", primed, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
